// File: rtl/slow_strobe_capture_fifo.sv
// Captures din into a show-ahead FIFO on synchronised edges of a slow strobe wclk.
// Optional macro STROBE_CNT_EN adds a saturating detected-edge counter output edge_cnt.
module slow_strobe_capture_fifo #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 0
) (
    input  logic                     rclk,
    input  logic                     rst_n,
    input  logic                     wclk,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf,
`ifdef STROBE_CNT_EN
    output logic [15:0]              edge_cnt,
`endif
    input  logic                     ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam bit RISE_EN = (EDGE_MODE == 0) || (EDGE_MODE == 2);
    localparam bit FALL_EN = (EDGE_MODE == 1) || (EDGE_MODE == 2);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;
    logic                   edge_r;
    logic                   rise_s;
    logic                   fall_s;

    logic [WIDTH-1:0]       mem_r [DEPTH];
    logic [PW-1:0]          wptr_r;
    logic [PW-1:0]          rptr_r;
    logic [PW-1:0]          count_r;
    logic [WIDTH-1:0]       dout_r;
    logic                   out_valid_r;
    logic                   ovf_r;

    logic                   rd_s;
    logic                   full_s;
    logic                   wr_en_s;
    logic                   drop_s;
    logic [PW-1:0]          rptr_nxt_s;
    logic [PW-1:0]          wptr_nxt_s;
    logic [PW-1:0]          count_nxt_s;
    logic [WIDTH-1:0]       dout_nxt_s;

    // Synchroniser chain, previous-sample flop and registered edge pulse
    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '0;
            prev_r <= 1'b0;
            edge_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], wclk};
            prev_r <= sync_r[SYNC_STAGES-1];
            edge_r <= (rise_s & RISE_EN) | (fall_s & FALL_EN);
        end
    end

    // Edge detection, FIFO control and next head value
    always_comb begin
        rise_s      = sync_r[SYNC_STAGES-1] & ~prev_r;
        fall_s      = ~sync_r[SYNC_STAGES-1] & prev_r;
        full_s      = (count_r == PW'(DEPTH));
        rd_s        = out_valid_r & out_ready;
        wr_en_s     = edge_r & (~full_s | rd_s);
        drop_s      = edge_r & full_s & ~rd_s;
        rptr_nxt_s  = rd_s ? (rptr_r + PW'(1)) : rptr_r;
        wptr_nxt_s  = wr_en_s ? (wptr_r + PW'(1)) : wptr_r;
        case ({wr_en_s, rd_s})
            2'b10:   count_nxt_s = count_r + PW'(1);
            2'b01:   count_nxt_s = count_r - PW'(1);
            default: count_nxt_s = count_r;
        endcase
        // A write landing in the slot that becomes the head must be forwarded from din
        if (count_nxt_s == PW'(0)) begin
            dout_nxt_s = dout_r;
        end else if (wr_en_s && (wptr_r == rptr_nxt_s)) begin
            dout_nxt_s = din;
        end else begin
            dout_nxt_s = mem_r[rptr_nxt_s[AW-1:0]];
        end
    end

    // FIFO storage, pointers, occupancy, registered head and overflow flag
    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wptr_r      <= '0;
            rptr_r      <= '0;
            count_r     <= '0;
            dout_r      <= '0;
            out_valid_r <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            if (wr_en_s) begin
                mem_r[wptr_r[AW-1:0]] <= din;
            end
            wptr_r      <= wptr_nxt_s;
            rptr_r      <= rptr_nxt_s;
            count_r     <= count_nxt_s;
            dout_r      <= dout_nxt_s;
            out_valid_r <= (count_nxt_s != PW'(0));
            if (drop_s) begin
                ovf_r <= 1'b1;
            end else if (ovf_clr) begin
                ovf_r <= 1'b0;
            end
        end
    end

    assign dout      = dout_r;
    assign out_valid = out_valid_r;
    assign count     = count_r;
    assign ovf       = ovf_r;

`ifdef STROBE_CNT_EN
    logic [15:0] edge_cnt_r;

    // Saturating count of every edge pulse, cleared together with ovf
    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt_r <= 16'h0000;
        end else if (ovf_clr) begin
            edge_cnt_r <= 16'h0000;
        end else if (edge_r && (edge_cnt_r != 16'hFFFF)) begin
            edge_cnt_r <= edge_cnt_r + 16'h0001;
        end
    end

    assign edge_cnt = edge_cnt_r;
`endif

endmodule

// File: doc/slow_strobe_capture_fifo.md
Name: slow_strobe_capture_fifo

Overview:
Parametrised successor to the slow-to-fast capture block, running entirely in the fast rclk domain. Synchronises a slow strobe clock (wclk) through a configurable flop chain and detects the selected edge(s) with a registered, glitch-free pulse. On each detected edge it captures WIDTH-bit din into a DEPTH-entry show-ahead FIFO. Data leaves the FIFO through a valid/ready handshake, with an occupancy count and a sticky overflow flag.

Parameters:
WIDTH, 8, data width of din/dout
DEPTH, 4, FIFO entries; power of 2, >=2
SYNC_STAGES, 2, wclk synchroniser flops; >=2
EDGE_MODE, 0, 0 = rising, 1 = falling, 2 = both edges of wclk trigger capture

Ports:
rclk  in  1  fast clock; all logic is on its rising edge
rst_n  in  1  asynchronous active-low reset
wclk  in  1  slow strobe, asynchronous to rclk
din  in  WIDTH  data; source holds it stable for >= SYNC_STAGES+2 rclk periods around each capturing wclk edge
dout  out  WIDTH  FIFO head data, valid when out_valid=1
out_valid  out  1  FIFO not empty
out_ready  in  1  consumer accepts head when out_valid & out_ready
count  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
ovf  out  1  sticky: a capture was dropped because the FIFO was full
ovf_clr  in  1  synchronous clear of ovf
edge_cnt  out  16  detected-edge counter; present only with STROBE_CNT_EN

Behaviour:
- Reset (rst_n=0, asynchronous): sync chain, prev flop, edge pulse, FIFO pointers, count, ovf = 0; dout = 0; out_valid = 0; edge_cnt = 0. Takes effect immediately, mid-operation included. Pending captures are lost.
- Synchroniser: s[0] <= wclk, s[i] <= s[i-1]; prev <= s[SYNC_STAGES-1].
- Edge pulse register: edge <= (rise & mode rise/both) | (fall & mode fall/both).
  - rise = s[last] & ~prev
  - fall = ~s[last] & prev
  - Exactly one rclk cycle wide per qualifying wclk transition.
- Capture: in the cycle where edge=1, din is written to FIFO[wptr] at the next rclk edge.
- Latency: wclk transition first sampled by s[0] at rclk edge k.
  - edge is high after edge k+SYNC_STAGES.
  - Write occurs at edge k+SYNC_STAGES+1.
  - out_valid rises after edge k+SYNC_STAGES+1.
  - There is no empty-FIFO bypass.
- FIFO: show-ahead. dout = mem[rptr] when count>0; dout holds its last value when empty.
  - Pointers are $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty. Pointers wrap naturally.
- Read: out_valid & out_ready advances rptr and decrements count. out_ready with an empty FIFO is ignored.
- Write while full:
  - If a read also occurs in the same cycle, the write is accepted and count is unchanged.
  - Otherwise the data is dropped, ovf <= 1, and count stays DEPTH.
- Simultaneous write and read when not full/empty: both occur; count is unchanged.
- ovf: set has priority over ovf_clr in the same cycle. Otherwise ovf_clr clears it.
- wclk pulses narrower than one rclk period may be missed. This is out of contract and is not flagged.

Optional Feature:
Macro STROBE_CNT_EN.
- Defined: adds output edge_cnt[15:0], which increments on every edge pulse (including dropped captures) and saturates at 16'hFFFF. It is reset to 0 by rst_n and cleared by ovf_clr. ovf_clr has priority over increment.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Latency: SYNC_STAGES=2, EDGE_MODE=0, din=8'hA5, wclk rises before rclk edge k -> out_valid=1 and dout=8'hA5 after edge k+3, count=1. Assert out_ready for one cycle -> out_valid=0, count=0.
- Edge modes: EDGE_MODE=2, one full wclk period with din=8'h11 then 8'h22 -> two entries read in order 11, 22. EDGE_MODE=1 -> only the falling-edge value is captured.
- Overflow: DEPTH=4, out_ready=0, 5 wclk rises with din=1..5 -> count=4, ovf=1. Reads return 1,2,3,4. ovf_clr -> ovf=0.
- Full with concurrent read: FIFO full, out_ready=1 in the write cycle -> count stays 4, ovf stays 0, new value appears at the tail.
- Reset mid-operation: assert rst_n=0 with count=3 and an edge in flight -> all outputs 0 immediately. After release, no stale capture appears.
- STROBE_CNT_EN: 6 edges, including 2 dropped captures -> edge_cnt=6. Forced near saturation -> holds at 16'hFFFF. ovf_clr -> 0.
